// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID->EX pipeline register of the 5-stage core.
//
// Registers the decoded instruction fields, the register-file read data and
// the Control_Unit outputs for the execute stage. The 32-bit immediate is
// also built here, from imm10/imm15/imm20 as selected by id_imm_src.
//
// Load-use hazard: when EX holds a load whose destination is read by the
// instruction in ID, stall_id holds PC and IF/ID for one cycle and a bubble
// is injected into EX. A saturating counter records the bubbles inserted.
//
// Handshake: there is no valid/ready pair. ID presents an instruction
// (id_valid) every cycle, and stall_id is the back-pressure to IF/ID:
//   - While stall_id=1, the upstream stages must present the same
//     instruction again on the next cycle.
//   - ex_stall is back-pressure from EX/MEM. While ex_stall=1, every ex_*
//     register holds.
//   - flush kills the ID->EX transfer. It has priority over ex_stall and
//     over the hazard.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   id_valid                     ID holds a real instruction
//   id_pc, id_opcode             pc_count_new and decoded opcode
//   id_rd, id_rn, id_rm          decoded register addresses
//   id_imm10/15/20               decoded immediate fields
//   id_rd1, id_rd2               register-file read data (rn, rm)
//   id_reg_write, id_mem_to_reg,
//   id_mem_write, id_alu_control Control_Unit outputs
//   id_imm_src                   immediate format select
//   flush                        branch taken in EX
//   ex_stall                     EX/MEM cannot accept
//   ex_*                         registered copies for the execute stage
//   ex_imm                       extended immediate
//   stall_id                     combinational: hold PC and IF/ID
//   bubble_cnt                   saturating load-use bubble count
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int RA_W   = 5,
  parameter int ALUC_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [5:0]        id_opcode,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [RA_W-1:0]   id_rn,
  input  logic [RA_W-1:0]   id_rm,
  input  logic [9:0]        id_imm10,
  input  logic [14:0]       id_imm15,
  input  logic [19:0]       id_imm20,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic [ALUC_W-1:0] id_alu_control,
  input  logic [1:0]        id_imm_src,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [5:0]        ex_opcode,
  output logic [RA_W-1:0]   ex_rd,
  output logic [RA_W-1:0]   ex_rn,
  output logic [RA_W-1:0]   ex_rm,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic [ALUC_W-1:0] ex_alu_control,
  output logic              stall_id,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // EX-side registers
  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [5:0]        r_opcode;
  logic [RA_W-1:0]   r_rd;
  logic [RA_W-1:0]   r_rn;
  logic [RA_W-1:0]   r_rm;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic              r_mem_write;
  logic [ALUC_W-1:0] r_alu_control;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic [DATA_W-1:0] w_imm;
  logic              w_rd_nonzero;
  logic              w_src_match;
  logic              w_hz;
  logic              w_cnt_sat;

  // Immediate extension. Format 11 is the only zero-extended one; it is
  // used for logical immediates.
  always_comb begin
    w_imm = '0;
    case (id_imm_src)
      2'b00:   w_imm = {{(DATA_W-10){id_imm10[9]}}, id_imm10};
      2'b01:   w_imm = {{(DATA_W-15){id_imm15[14]}}, id_imm15};
      2'b10:   w_imm = {{(DATA_W-20){id_imm20[19]}}, id_imm20};
      default: w_imm = {{(DATA_W-15){1'b0}}, id_imm15};
    endcase
  end

  // Load-use detection. r0 is hard-wired to zero, so a load targeting r0
  // never creates a dependency. A bubble clears r_valid, which releases the
  // hazard on the next cycle, so each load-use costs exactly one bubble.
  assign w_rd_nonzero = (r_rd != '0);
  assign w_src_match  = (r_rd == id_rn) || (r_rd == id_rm);
  assign w_hz         = r_valid && r_mem_to_reg && id_valid &&
                        w_rd_nonzero && w_src_match;

  // flush is deliberately absent here, which avoids a combinational path
  // from the branch unit back into PC/IF-ID enable.
  assign stall_id  = !rst && (w_hz || ex_stall);

  assign w_cnt_sat = &r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_opcode      <= '0;
      r_rd          <= '0;
      r_rn          <= '0;
      r_rm          <= '0;
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm         <= '0;
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_mem_write   <= 1'b0;
      r_alu_control <= '0;
      r_bubble_cnt  <= '0;
    end else if (flush) begin
      // A killed instruction must not write anything downstream. Data
      // fields are don't-care once valid is low, so they hold.
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (ex_stall) begin
      // Hold everything, including the bubble counter.
      r_valid <= r_valid;
    end else if (w_hz) begin
      // Bubble. The data fields hold, so ex_rd still names the load's
      // destination, but valid is low and no further hazard is raised.
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_write  <= 1'b0;
      if (!w_cnt_sat) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end else begin
      r_valid       <= id_valid;
      r_pc          <= id_pc;
      r_opcode      <= id_opcode;
      r_rd          <= id_rd;
      r_rn          <= id_rn;
      r_rm          <= id_rm;
      r_rd1         <= id_rd1;
      r_rd2         <= id_rd2;
      r_imm         <= w_imm;
      r_alu_control <= id_alu_control;
      // Keep the invariant: ex_valid=0 implies no write enables.
      r_reg_write   <= id_valid && id_reg_write;
      r_mem_to_reg  <= id_valid && id_mem_to_reg;
      r_mem_write   <= id_valid && id_mem_write;
    end
  end

  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_opcode      = r_opcode;
  assign ex_rd          = r_rd;
  assign ex_rn          = r_rn;
  assign ex_rm          = r_rm;
  assign ex_rd1         = r_rd1;
  assign ex_rd2         = r_rd2;
  assign ex_imm         = r_imm;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_to_reg  = r_mem_to_reg;
  assign ex_mem_write   = r_mem_write;
  assign ex_alu_control = r_alu_control;
  assign bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// The driver issues one stimulus vector per cycle. On each vector it updates
// a reference model of the EX register and pushes the expected stall_id and
// post-edge EX contents onto exp_q. A monitor process pops exp_q: it checks
// stall_id before the edge and the EX registers after it.
//
// The DUT is built with CNT_W=4, so saturation of bubble_cnt is reachable.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int PC_W   = 16;
  localparam int RA_W   = 5;
  localparam int ALUC_W = 4;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic              rst;
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [5:0]        opcode;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rn;
    logic [RA_W-1:0]   rm;
    logic [9:0]        imm10;
    logic [14:0]       imm15;
    logic [19:0]       imm20;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [ALUC_W-1:0] aluc;
    logic [1:0]        imm_src;
    logic              flush;
    logic              ex_stall;
  } stim_t;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [5:0]        opcode;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rn;
    logic [RA_W-1:0]   rm;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [ALUC_W-1:0] aluc;
    logic [CNT_W-1:0]  cnt;
  } ex_t;

  typedef struct packed {
    logic stall;
    ex_t  ex;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic [PC_W-1:0]   id_pc = '0;
  logic [5:0]        id_opcode = '0;
  logic [RA_W-1:0]   id_rd = '0, id_rn = '0, id_rm = '0;
  logic [9:0]        id_imm10 = '0;
  logic [14:0]       id_imm15 = '0;
  logic [19:0]       id_imm20 = '0;
  logic [DATA_W-1:0] id_rd1 = '0, id_rd2 = '0;
  logic              id_reg_write = 1'b0, id_mem_to_reg = 1'b0, id_mem_write = 1'b0;
  logic [ALUC_W-1:0] id_alu_control = '0;
  logic [1:0]        id_imm_src = '0;
  logic              flush = 1'b0, ex_stall = 1'b0;

  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic [5:0]        ex_opcode;
  logic [RA_W-1:0]   ex_rd, ex_rn, ex_rm;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
  logic              ex_reg_write, ex_mem_to_reg, ex_mem_write;
  logic [ALUC_W-1:0] ex_alu_control;
  logic              stall_id;
  logic [CNT_W-1:0]  bubble_cnt;

  id_ex_stage #(
    .DATA_W(DATA_W), .PC_W(PC_W), .RA_W(RA_W), .ALUC_W(ALUC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm),
    .id_imm10(id_imm10), .id_imm15(id_imm15), .id_imm20(id_imm20),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_alu_control(id_alu_control), .id_imm_src(id_imm_src),
    .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rn(ex_rn), .ex_rm(ex_rm),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_control(ex_alu_control),
    .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  ex_t  m;  // reference model: what EX holds after the most recent edge

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Immediate value computed as a signed integer from the field width.
  function automatic logic [DATA_W-1:0] ref_imm(input stim_t s);
    int unsigned v;
    case (s.imm_src)
      2'd0: v = (s.imm10 >= 10'd512)    ? 32'(s.imm10) - 32'd1024    : 32'(s.imm10);
      2'd1: v = (s.imm15 >= 15'd16384)  ? 32'(s.imm15) - 32'd32768   : 32'(s.imm15);
      2'd2: v = (s.imm20 >= 20'd524288) ? 32'(s.imm20) - 32'd1048576 : 32'(s.imm20);
      default: v = 32'(s.imm15);
    endcase
    return v;
  endfunction

  // Advance the model by one edge; returns the stall expected before it.
  task automatic model_step(input stim_t s, output logic stall_exp, output ex_t nxt);
    logic load_use;
    nxt = m;
    load_use = m.valid && m.mem_to_reg && s.valid && (m.rd != 0) &&
               (m.rd == s.rn || m.rd == s.rm);
    stall_exp = !s.rst && (load_use || s.ex_stall);
    if (s.rst) begin
      nxt = '0;
    end else if (s.flush || (!s.ex_stall && load_use)) begin
      nxt.valid = 0; nxt.reg_write = 0; nxt.mem_to_reg = 0; nxt.mem_write = 0;
      if (!s.flush && nxt.cnt != 4'd15) nxt.cnt = nxt.cnt + 1;
    end else if (!s.ex_stall) begin
      nxt.valid = s.valid;
      nxt.pc = s.pc; nxt.opcode = s.opcode;
      nxt.rd = s.rd; nxt.rn = s.rn; nxt.rm = s.rm;
      nxt.rd1 = s.rd1; nxt.rd2 = s.rd2; nxt.imm = ref_imm(s);
      nxt.aluc = s.aluc;
      nxt.reg_write  = s.valid ? s.reg_write  : 1'b0;
      nxt.mem_to_reg = s.valid ? s.mem_to_reg : 1'b0;
      nxt.mem_write  = s.valid ? s.mem_write  : 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst = s.rst; id_valid = s.valid; id_pc = s.pc; id_opcode = s.opcode;
    id_rd = s.rd; id_rn = s.rn; id_rm = s.rm;
    id_imm10 = s.imm10; id_imm15 = s.imm15; id_imm20 = s.imm20;
    id_rd1 = s.rd1; id_rd2 = s.rd2;
    id_reg_write = s.reg_write; id_mem_to_reg = s.mem_to_reg; id_mem_write = s.mem_write;
    id_alu_control = s.aluc; id_imm_src = s.imm_src;
    flush = s.flush; ex_stall = s.ex_stall;
    model_step(s, e.stall, e.ex);
    m = e.ex;
    exp_q.push_back(e);
  endtask

  function automatic stim_t base_stim();
    stim_t s = '0;
    s.valid = 1'b1;
    s.opcode = 6'(32'h11);
    s.pc = 16'h0100;
    return s;
  endfunction

  function automatic stim_t load_stim(input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rn);
    stim_t s = base_stim();
    s.rd = rd; s.rn = rn; s.rm = 5'd31;
    s.mem_to_reg = 1'b1; s.reg_write = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst        = ($urandom_range(99) < 2);
    s.valid      = ($urandom_range(99) < 85);
    s.pc         = 16'($urandom);
    s.opcode     = 6'($urandom);
    s.rd         = 5'($urandom_range(3));
    s.rn         = 5'($urandom_range(3));
    s.rm         = 5'($urandom_range(4));
    s.imm10      = 10'($urandom);
    s.imm15      = 15'($urandom);
    s.imm20      = 20'($urandom);
    s.rd1        = $urandom;
    s.rd2        = $urandom;
    s.reg_write  = 1'($urandom);
    s.mem_to_reg = ($urandom_range(99) < 50);
    s.mem_write  = 1'($urandom);
    s.aluc       = 4'($urandom);
    s.imm_src    = 2'($urandom);
    s.flush      = ($urandom_range(99) < 10);
    s.ex_stall   = ($urandom_range(99) < 20);
    return s;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    ex_t  act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("stall_id", 128'(stall_id), 128'(e.stall));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        act = '{ex_valid, ex_pc, ex_opcode, ex_rd, ex_rn, ex_rm, ex_rd1, ex_rd2,
                ex_imm, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_control,
                bubble_cnt};
        check("ex_ctrl", 128'({act.valid, act.reg_write, act.mem_to_reg, act.mem_write}),
              128'({e.ex.valid, e.ex.reg_write, e.ex.mem_to_reg, e.ex.mem_write}));
        check("bubble_cnt", 128'(act.cnt), 128'(e.ex.cnt));
        // Data fields are meaningful only for a real instruction.
        if (e.ex.valid) begin
          check("ex_pc_op_regs", 128'({act.pc, act.opcode, act.rd, act.rn, act.rm, act.aluc}),
                128'({e.ex.pc, e.ex.opcode, e.ex.rd, e.ex.rn, e.ex.rm, e.ex.aluc}));
          check("ex_rd1_rd2", 128'({act.rd1, act.rd2}), 128'({e.ex.rd1, e.ex.rd2}));
          check("ex_imm", 128'(act.imm), 128'(e.ex.imm));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    stim_t s;
    m = '0;

    // Reset for two cycles with a valid instruction present.
    s = base_stim(); s.rst = 1'b1;
    drive(s);
    drive(s);

    // Pass-through with a negative imm15.
    s = base_stim();
    s.pc = 16'h0010; s.rd1 = 32'hDEADBEEF; s.imm_src = 2'b01; s.imm15 = 15'h4000;
    drive(s);

    // Load-use: load r5, then a reader of r5 (held for the bubble cycle).
    drive(load_stim(5'd5, 5'd1));
    s = base_stim(); s.rn = 5'd5; s.rd = 5'd6; s.rd1 = 32'h1234_5678;
    drive(s);
    drive(s);

    // Load to r0: a reader of r0 must not stall.
    drive(load_stim(5'd0, 5'd1));
    s = base_stim(); s.rn = 5'd0; s.rm = 5'd0;
    drive(s);

    // flush + ex_stall + hazard together.
    drive(load_stim(5'd7, 5'd1));
    s = base_stim(); s.rn = 5'd7; s.flush = 1'b1; s.ex_stall = 1'b1;
    drive(s);

    // ex_stall for three cycles, then release.
    s = base_stim(); s.pc = 16'h0200; s.rd2 = 32'hCAFE_0001;
    drive(s);
    s = base_stim(); s.pc = 16'h0204; s.ex_stall = 1'b1; s.imm_src = 2'b11; s.imm15 = 15'h7FFF;
    repeat (3) drive(s);
    s.ex_stall = 1'b0;
    drive(s);

    // Saturation: alternating dependent loads give a bubble every other cycle.
    repeat (40) drive(load_stim(5'd3, 5'd3));
    @(posedge clk);
    #1;
    check("bubble_cnt_saturated", 128'(bubble_cnt), 128'(4'hF));

    // Random traffic.
    s = base_stim(); s.rst = 1'b1;
    drive(s);
    repeat (600) drive(rand_stim());

    // Drain.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
